// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic initiator driven by a valid/ready command
// stream. Each accepted command becomes one single read or write cycle on
// the wbm_* port, and its result comes back on a valid/ready response stream.
// Only one cycle is ever outstanding.
//
// Optional build macro:
//   WBM_TIMEOUT_EN  abort a bus cycle after TIMEOUT cycles without ack and
//                   return rsp_err=1. When undefined the master waits for
//                   ack indefinitely and rsp_err is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | cmd_ready high, waiting for a command
// S_BUS  | cyc/stb asserted, request fields held, waiting for ack
// S_RESP | response presented, waiting for rsp_ready

module wb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_cmd_ready;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_dat;
  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [SW-1:0]   r_sel;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_dat;

`ifdef WBM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]   r_cnt;
  logic            r_rsp_err;
  logic            w_tmo;

  // The edge on which the count would reach TIMEOUT is the abort edge.
  assign w_tmo   = (r_cnt == CW'(TIMEOUT - 1));
  assign rsp_err = r_rsp_err;
`else
  logic [31:0]     w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT);
  assign rsp_err          = 1'b0;
`endif

  // Command/bus/response sequencer with all outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
`ifdef WBM_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_we        <= cmd_we;
            r_adr       <= cmd_adr;
            r_dat       <= cmd_dat;
            r_sel       <= cmd_sel;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
`ifdef WBM_TIMEOUT_EN
            r_cnt       <= '0;
`endif
            r_state     <= S_BUS;
          end
        end

        S_BUS: begin
          // Ack has priority over the timeout when both land on one edge.
          if (wbm_ack_i) begin
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
`ifdef WBM_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= S_RESP;
          end
`ifdef WBM_TIMEOUT_EN
          else if (w_tmo) begin
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
          end
`endif
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master. A memory-backed Wishbone slave model answers
// the bus; a reference memory predicts every response when the command is
// issued, and a monitor pops and compares responses as they are handed over.

module tb_wb_cmd_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam logic [31:0] SEED_XOR = 32'h5EED_C0DE;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [31:0]   cmd_adr;
  logic [31:0]   cmd_dat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic [31:0]   wbm_dat_i;
  logic          wbm_ack_i;

  always #5 clk = ~clk;

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          dly;
  } cmd_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  cmd_t        cmdq[$];
  rsp_t        expq[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ SEED_XOR);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : (a ^ SEED_XOR);
  endfunction

  // Present one command, wait for acceptance, then record what must come back.
  // dly = number of slave wait cycles before ack (>= TMO means never acked).
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int dly, input bit exp_rsp);
    cmd_t c;
    rsp_t r;
    bit   accepted;
    bit   timed_out;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    accepted  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    c.we = we; c.adr = adr; c.dat = dat; c.sel = sel; c.dly = dly;
    cmdq.push_back(c);
    if (exp_rsp) begin
`ifdef WBM_TIMEOUT_EN
      timed_out = (dly >= TMO);
`else
      timed_out = 1'b0;
`endif
      if (timed_out) begin
        r.dat = '0; r.err = 1'b1;
      end else if (we) begin
        ref_mem[adr] = merge(ref_rd(adr), dat, sel);
        r.dat = '0; r.err = 1'b0;
      end else begin
        r.dat = ref_rd(adr); r.err = 1'b0;
      end
      expq.push_back(r);
    end
  endtask

  // Slave model: checks the request, waits its delay, then acks; stray acks when idle.
  initial begin : slave
    cmd_t cur;
    bit   busy;
    int   cnt;
    busy      = 1'b0;
    cnt       = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    cur.we = 1'b0; cur.adr = '0; cur.dat = '0; cur.sel = '0; cur.dly = 0;
    forever begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_stb_o) begin
        if (!busy) begin
          busy = 1'b1;
          if (cmdq.size() == 0) begin
            check("unexpected_bus_cycle", 32'(cmdq.size()), 32'd1);
            cur.we = wbm_we_o; cur.adr = wbm_adr_o; cur.dat = wbm_dat_o;
            cur.sel = wbm_sel_o; cur.dly = 1000;
          end else begin
            cur = cmdq.pop_front();
          end
          cnt = cur.dly;
          check("cmd_ready_in_bus", 32'(cmd_ready), 32'd0);
        end
        check("bus_we",  32'(wbm_we_o),  32'(cur.we));
        check("bus_adr", wbm_adr_o,      cur.adr);
        check("bus_dat", wbm_dat_o,      cur.dat);
        check("bus_sel", 32'(wbm_sel_o), 32'(cur.sel));
        if (cnt == 0) begin
          wbm_ack_i = 1'b1;
          if (wbm_we_o) begin
            slv_mem[wbm_adr_o] = merge(slv_rd(wbm_adr_o), wbm_dat_o, wbm_sel_o);
            wbm_dat_i = $urandom;
          end else begin
            wbm_dat_i = slv_rd(wbm_adr_o);
          end
        end else begin
          cnt--;
          wbm_ack_i = 1'b0;
          wbm_dat_i = $urandom;
        end
      end else begin
        busy      = 1'b0;
        wbm_ack_i = ($urandom_range(0, 3) == 0);
        wbm_dat_i = $urandom;
      end
    end
  end

  // Response monitor: random back-pressure, hold stability, and scoreboard pop.
  initial begin : monitor
    rsp_t        e;
    bit          held;
    logic [31:0] prev_dat;
    logic        prev_err;
    held      = 1'b0;
    prev_dat  = '0;
    prev_err  = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (rsp_valid) begin
        check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        check("cyc_in_resp",       32'(wbm_cyc_o), 32'd0);
        if (held) begin
          check("rsp_dat_hold", rsp_dat,       prev_dat);
          check("rsp_err_hold", 32'(rsp_err),  32'(prev_err));
        end
        if (rsp_ready) begin
          held = 1'b0;
          if (expq.size() == 0) begin
            check("unexpected_response", 32'(expq.size()), 32'd1);
          end else begin
            e = expq.pop_front();
            check("rsp_dat", rsp_dat,      e.dat);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end else begin
          held     = 1'b1;
          prev_dat = rsp_dat;
          prev_err = rsp_err;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && cmdq.size() == 0 && !rsp_valid && !wbm_cyc_o) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_outstanding", 32'(expq.size() + cmdq.size()), 32'd0);
    if (!done) check("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_dat"},   rsp_dat,        32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_cyc"},       32'(wbm_cyc_o), 32'd0);
    check({tag, "_stb"},       32'(wbm_stb_o), 32'd0);
    check({tag, "_we"},        32'(wbm_we_o),  32'd0);
    check({tag, "_sel"},       32'(wbm_sel_o), 32'd0);
    check({tag, "_adr"},       wbm_adr_o,      32'd0);
    check({tag, "_dat_o"},     wbm_dat_o,      32'd0);
  endtask

  initial begin : stimulus
    logic [31:0] a;
    int          d;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Directed: write with 2 wait cycles, same-cycle ack, read-back.
    issue(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 2, 1'b1);
    issue(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 0, 1'b1);
    issue(1'b0, 32'h3000_0000, 32'hDEAD_0000, 4'hF, 0, 1'b1);
    issue(1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 1, 1'b1);
    issue(1'b0, 32'h3000_0010, 32'h0000_0000, 4'h3, 0, 1'b1);

    // Random traffic over a small window so reads hit earlier writes.
    for (int n = 0; n < 150; n++) begin
      a = 32'h3000_0000 + 32'(4 * $urandom_range(0, 7));
`ifdef WBM_TIMEOUT_EN
      d = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
`else
      d = $urandom_range(0, 3);
`endif
      issue($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), d, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef WBM_TIMEOUT_EN
    // Never acked -> timeout; ack on the timeout edge -> normal response.
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, 50, 1'b1);
    issue(1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'hF, 50, 1'b1);
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, TMO - 1, 1'b1);
    issue(1'b1, 32'h3000_000C, 32'h0BAD_BEEF, 4'hF, TMO - 1, 1'b1);
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 1'b1);
`endif
    drain();

    // Reset in the middle of a bus cycle drops the command silently.
    issue(1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF, 5000, 1'b0);
    @(negedge clk);
    check("cyc_before_reset", 32'(wbm_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midbus_reset");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end

    // Recovery: the dropped write never reached the slave.
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 1'b1);
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
